aes_activity_sched: RTL and testbench
=====================================

Name: aes_activity_sched

Overview:
- Sequencer that drives the AES_Comp_ENC core as a controlled switching-activity load for the ring-oscillator sensor experiments.
- Handles core reset, key load and repeated encryptions in a fixed-length or free-running burst.
- Inserts optional idle gaps with the core disabled.
- Chains or counts plaintexts and monitors the core with a watchdog. Sits between the experiment control logic and the AES core.

Parameters:
CNT_W, 16, width of burst_len, idle_len, enc_count
TIMEOUT, 1023, max cycles waiting for aes_kvld/aes_dvld before error

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
start  in  1  one-cycle pulse; begin a burst (ignored unless IDLE or ERR)
stop  in  1  one-cycle pulse; end burst at next encryption boundary
chain  in  1  1: next plaintext = last ciphertext; 0: plaintext + 1 (mod 2^128)
key_in  in  128  key, sampled on accepted start
pt_in  in  128  first plaintext, sampled on accepted start
burst_len  in  CNT_W  encryptions per burst; 0 = run until stop
idle_len  in  CNT_W  core-disabled cycles between encryptions; sampled on start
aes_kin  out  128  to core Kin
aes_din  out  128  to core Din
aes_krdy  out  1  to core Krdy
aes_drdy  out  1  to core Drdy
aes_rstn  out  1  to core RSTn
aes_en  out  1  to core EN
aes_dout  in  128  from core Dout
aes_bsy  in  1  from core BSY (status only)
aes_kvld  in  1  from core Kvld
aes_dvld  in  1  from core Dvld
busy  out  1  high in any state except IDLE/ERR
done  out  1  one-cycle pulse at burst end
err  out  1  sticky watchdog error; cleared by accepted start
enc_count  out  CNT_W  encryptions completed this burst (wraps)
last_ct  out  128  most recent ciphertext

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all outputs 0, including aes_rstn=0 and aes_en=0.
  - Latched key, pt and lengths cleared.
- All outputs are registered.
- States: IDLE, CORE_RST, LOAD_KEY, WAIT_KVLD, LOAD_DATA, WAIT_DVLD, GAP, FINISH, ERR.
- IDLE:
  - aes_rstn=0, aes_en=0.
  - On start: latch key_in→aes_kin, pt_in→aes_din, burst_len, idle_len; clear enc_count and err; go CORE_RST.
- CORE_RST (1 cycle): aes_en=1, aes_rstn=0. Then LOAD_KEY with aes_rstn=1.
- LOAD_KEY (1 cycle): aes_krdy=1. Then WAIT_KVLD.
- WAIT_KVLD: on aes_kvld go LOAD_DATA.
- LOAD_DATA (1 cycle): aes_drdy=1, aes_din stable. Then WAIT_DVLD.
- WAIT_DVLD, on aes_dvld:
  - last_ct<=aes_dout; enc_count+1.
  - aes_din <= aes_dout if chain, else aes_din+1.
  - chain is sampled at this cycle, not at start.
  - Then:
    - stop pending, or burst_len≠0 and new count==burst_len → FINISH.
    - else idle_len==0 → LOAD_DATA.
    - else → GAP.
- GAP:
  - aes_en=0 for exactly idle_len cycles, then LOAD_DATA with aes_en=1.
  - A stop in GAP → FINISH next cycle.
- FINISH (1 cycle): done=1, aes_en=0, aes_rstn=0. Then IDLE.
- Latency: start → first aes_drdy = 3 cycles + key-expansion wait.
- stop:
  - Captured into a pending flag in any busy state; pending flag cleared on entry to IDLE.
  - An encryption in flight (WAIT_DVLD) always completes and is counted.
  - stop in CORE_RST/LOAD_KEY/WAIT_KVLD: key load completes, then FINISH with zero encryptions instead of LOAD_DATA.
  - stop in IDLE is ignored.
- start while busy: ignored.
- start and stop in the same cycle in IDLE: start accepted, stop ignored.
- Watchdog:
  - Cycle counter reset on entering WAIT_KVLD/WAIT_DVLD.
  - Reaching TIMEOUT without the valid → ERR: err=1, aes_rstn=0, aes_en=0, busy=0, no done pulse.
  - ERR is left only by start, which behaves as from IDLE.
- enc_count wraps 2^CNT_W−1→0 in free-running mode without side effects.
- aes_kvld/aes_dvld in states not waiting for them: ignored.
- aes_bsy does not affect sequencing.
- Reset asserted mid-burst: immediate return to reset values, no done pulse.

Test Plan:
- FIPS-197 vector:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, burst_len=1, idle_len=0.
  - Response: last_ct=69c4e0d86a7b0430d8cdb78070b4c55a, enc_count=1, single done pulse, busy low after.
- Chaining:
  - Stimulus: chain=1, burst_len=3, idle_len=5.
  - Response: three aes_drdy pulses; aes_en low exactly 5 cycles between each dvld and next drdy; second aes_din equals first ciphertext; enc_count=3.
- Free-running counter mode with stop:
  - Stimulus: chain=0, burst_len=0; stop asserted mid-WAIT_DVLD of encryption 10.
  - Response: encryption 10 completes, enc_count=10, aes_din = pt+10, done one cycle later.
- Watchdog:
  - Stimulus: core model never raises aes_dvld, TIMEOUT=1023.
  - Response: err=1 exactly 1023 cycles after WAIT_DVLD entry; busy=0; no done; subsequent start clears err and completes normally.
- Boundary handling:
  - start while busy → no effect.
  - start+stop same cycle from IDLE → full burst runs.
  - rst_n low mid-GAP → all outputs 0 asynchronously.
- Stop during key load:
  - Stimulus: stop during WAIT_KVLD.
  - Response: no aes_drdy issued, enc_count=0, done pulse after kvld.

Source files
------------

// File: rtl/aes_activity_sched.sv
// aes_activity_sched
// Sequences an AES_Comp_ENC core as a controllable switching-activity load.
// It resets the core, loads the key and then runs a burst of encryptions.
// A burst is either a fixed count or free-running until stop.
// Optional core-disabled idle gaps separate the encryptions.
// Each new plaintext is either the last ciphertext (chain) or the previous
// plaintext + 1. A watchdog aborts into ERR if the core stops answering.
//
// Ports
//   clk, rst_n            system clock, async active-low reset
//   start, stop           one-cycle control pulses
//   chain                 plaintext chaining select (sampled per encryption)
//   key_in, pt_in         key / first plaintext, latched on accepted start
//   burst_len, idle_len   encryptions per burst (0 = free run), gap cycles
//   aes_kin .. aes_en     registered drive to the core
//   aes_dout .. aes_dvld  core responses (aes_bsy is status only)
//   busy, done, err       sequencer status
//   enc_count, last_ct    encryptions this burst, most recent ciphertext
//
// state       | meaning
// ------------+--------------------------------------------------------
// IDLE        | core held in reset and disabled, waiting for start
// CORE_RST    | core enabled, reset still asserted for one cycle
// LOAD_KEY    | Krdy pulse
// WAIT_KVLD   | waiting for key expansion (watchdog running)
// LOAD_DATA   | Drdy pulse with current plaintext
// WAIT_DVLD   | waiting for ciphertext (watchdog running)
// GAP         | core disabled for idle_len cycles
// FINISH      | done pulse, core back in reset
// ERR         | watchdog expired; sticky until next start
module aes_activity_sched #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             chain,
  input  logic [127:0]     key_in,
  input  logic [127:0]     pt_in,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [CNT_W-1:0] idle_len,
  output logic [127:0]     aes_kin,
  output logic [127:0]     aes_din,
  output logic             aes_krdy,
  output logic             aes_drdy,
  output logic             aes_rstn,
  output logic             aes_en,
  input  logic [127:0]     aes_dout,
  input  logic             aes_bsy,
  input  logic             aes_kvld,
  input  logic             aes_dvld,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] enc_count,
  output logic [127:0]     last_ct
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_CORE_RST  = 4'd1;
  localparam logic [3:0] S_LOAD_KEY  = 4'd2;
  localparam logic [3:0] S_WAIT_KVLD = 4'd3;
  localparam logic [3:0] S_LOAD_DATA = 4'd4;
  localparam logic [3:0] S_WAIT_DVLD = 4'd5;
  localparam logic [3:0] S_GAP       = 4'd6;
  localparam logic [3:0] S_FINISH    = 4'd7;
  localparam logic [3:0] S_ERR       = 4'd8;

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  // Loaded on entry to a wait state; reaching zero with no valid means
  // TIMEOUT cycles have elapsed since entry.
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

  logic [3:0]       state;
  logic             stop_pend;
  logic             stop_now;
  logic [CNT_W-1:0] burst_q;
  logic [CNT_W-1:0] idle_q;
  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [WD_W-1:0]  wd_cnt;
  logic             burst_hit;
  logic             unused_bsy;

  assign unused_bsy = aes_bsy;
  // A stop arriving in the same cycle as the boundary counts as pending.
  assign stop_now   = stop_pend | stop;
  assign cnt_next   = enc_count + CNT_W'(1);
  assign burst_hit  = (burst_q != '0) && (cnt_next == burst_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      stop_pend <= 1'b0;
      burst_q   <= '0;
      idle_q    <= '0;
      gap_cnt   <= '0;
      wd_cnt    <= '0;
      aes_kin   <= '0;
      aes_din   <= '0;
      aes_krdy  <= 1'b0;
      aes_drdy  <= 1'b0;
      aes_rstn  <= 1'b0;
      aes_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      enc_count <= '0;
      last_ct   <= '0;
    end else begin
      if (state != S_IDLE && state != S_ERR)
        stop_pend <= stop_pend | stop;

      case (state)
        S_IDLE, S_ERR: begin
          if (start) begin
            aes_kin   <= key_in;
            aes_din   <= pt_in;
            burst_q   <= burst_len;
            idle_q    <= idle_len;
            enc_count <= '0;
            err       <= 1'b0;
            busy      <= 1'b1;
            aes_en    <= 1'b1;
            aes_rstn  <= 1'b0;
            stop_pend <= 1'b0;
            state     <= S_CORE_RST;
          end
        end

        S_CORE_RST: begin
          aes_rstn <= 1'b1;
          aes_krdy <= 1'b1;
          state    <= S_LOAD_KEY;
        end

        S_LOAD_KEY: begin
          aes_krdy <= 1'b0;
          wd_cnt   <= WD_LOAD;
          state    <= S_WAIT_KVLD;
        end

        S_WAIT_KVLD: begin
          if (aes_kvld) begin
            if (stop_now) begin
              done     <= 1'b1;
              aes_en   <= 1'b0;
              aes_rstn <= 1'b0;
              state    <= S_FINISH;
            end else begin
              aes_drdy <= 1'b1;
              state    <= S_LOAD_DATA;
            end
          end else if (wd_cnt == '0) begin
            err       <= 1'b1;
            busy      <= 1'b0;
            aes_rstn  <= 1'b0;
            aes_en    <= 1'b0;
            stop_pend <= 1'b0;
            state     <= S_ERR;
          end else begin
            wd_cnt <= wd_cnt - WD_W'(1);
          end
        end

        S_LOAD_DATA: begin
          aes_drdy <= 1'b0;
          wd_cnt   <= WD_LOAD;
          state    <= S_WAIT_DVLD;
        end

        S_WAIT_DVLD: begin
          if (aes_dvld) begin
            last_ct   <= aes_dout;
            enc_count <= cnt_next;
            aes_din   <= chain ? aes_dout : aes_din + 128'd1;
            if (stop_now || burst_hit) begin
              done     <= 1'b1;
              aes_en   <= 1'b0;
              aes_rstn <= 1'b0;
              state    <= S_FINISH;
            end else if (idle_q == '0) begin
              aes_drdy <= 1'b1;
              state    <= S_LOAD_DATA;
            end else begin
              aes_en  <= 1'b0;
              gap_cnt <= idle_q - CNT_W'(1);
              state   <= S_GAP;
            end
          end else if (wd_cnt == '0) begin
            err       <= 1'b1;
            busy      <= 1'b0;
            aes_rstn  <= 1'b0;
            aes_en    <= 1'b0;
            stop_pend <= 1'b0;
            state     <= S_ERR;
          end else begin
            wd_cnt <= wd_cnt - WD_W'(1);
          end
        end

        S_GAP: begin
          if (stop_now) begin
            done     <= 1'b1;
            aes_rstn <= 1'b0;
            state    <= S_FINISH;
          end else if (gap_cnt == '0) begin
            aes_en   <= 1'b1;
            aes_drdy <= 1'b1;
            state    <= S_LOAD_DATA;
          end else begin
            gap_cnt <= gap_cnt - CNT_W'(1);
          end
        end

        S_FINISH: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          stop_pend <= 1'b0;
          state     <= S_IDLE;
        end

        default: begin
          busy      <= 1'b0;
          aes_en    <= 1'b0;
          aes_rstn  <= 1'b0;
          aes_krdy  <= 1'b0;
          aes_drdy  <= 1'b0;
          done      <= 1'b0;
          stop_pend <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_activity_sched.sv
// Directed bench for aes_activity_sched with a behavioural AES core stand-in.
// The stand-in returns the FIPS-197 ciphertext for the FIPS key/plaintext pair
// and a simple scrambling function for anything else.
module tb_aes_activity_sched;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, stop = 1'b0, chain = 1'b0;
  logic [127:0] key_in = '0, pt_in = '0;
  logic [15:0]  burst_len = '0, idle_len = '0;
  logic [127:0] aes_kin, aes_din;
  logic         aes_krdy, aes_drdy, aes_rstn, aes_en;
  logic [127:0] aes_dout = '0;
  logic         aes_bsy = 1'b0, aes_kvld = 1'b0, aes_dvld = 1'b0;
  logic         busy, done, err;
  logic [15:0]  enc_count;
  logic [127:0] last_ct;

  int errors = 0;
  int checks = 0;

  aes_activity_sched #(.CNT_W(16), .TIMEOUT(1023)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .chain(chain),
    .key_in(key_in), .pt_in(pt_in), .burst_len(burst_len), .idle_len(idle_len),
    .aes_kin(aes_kin), .aes_din(aes_din), .aes_krdy(aes_krdy),
    .aes_drdy(aes_drdy), .aes_rstn(aes_rstn), .aes_en(aes_en),
    .aes_dout(aes_dout), .aes_bsy(aes_bsy), .aes_kvld(aes_kvld),
    .aes_dvld(aes_dvld), .busy(busy), .done(done), .err(err),
    .enc_count(enc_count), .last_ct(last_ct)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] model_enc(input logic [127:0] k, input logic [127:0] d);
    if (k == FIPS_KEY && d == FIPS_PT) return FIPS_CT;
    return {d[63:0], d[127:64]} ^ k ^ 128'ha5a5_5a5a_0f0f_f0f0_1234_5678_9abc_def0;
  endfunction

  // core stand-in, driven on the falling edge
  int           klat = 2;
  int           kcnt = 0;
  int           dcnt = 0;
  logic         hang_dvld = 1'b0;
  logic [127:0] d_lat = '0, k_lat = '0;

  always @(negedge clk) begin
    aes_kvld = 1'b0;
    aes_dvld = 1'b0;
    aes_bsy  = (dcnt != 0);
    if (kcnt != 0) begin
      kcnt = kcnt - 1;
      if (kcnt == 0) aes_kvld = 1'b1;
    end
    if (dcnt != 0) begin
      dcnt = dcnt - 1;
      if (dcnt == 0 && !hang_dvld) begin
        aes_dvld = 1'b1;
        aes_dout = model_enc(k_lat, d_lat);
      end
    end
    if (aes_krdy) kcnt = klat;
    if (aes_drdy) begin
      dcnt  = 2;
      d_lat = aes_din;
      k_lat = aes_kin;
    end
  end

  // activity monitor
  logic [127:0] din_q[$];
  int           gap_q[$];
  int           low_run = 0;
  int           done_cnt = 0;

  always @(negedge clk) begin
    if (busy && !aes_en) low_run = low_run + 1;
    if (aes_drdy) begin
      din_q.push_back(aes_din);
      gap_q.push_back(low_run);
      low_run = 0;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic with_stop);
    start = 1'b1;
    stop  = with_stop;
    step();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic wait_drdy(input int count, input int budget);
    int n;
    n = 0;
    while (din_q.size() < count && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic clear_mon();
    din_q.delete();
    gap_q.delete();
    low_run = 0;
  endtask

  int           dc0;
  logic [127:0] c1, c2, c3;

  initial begin
    // ---------------- reset state
    step(); step();
    check("rst_busy",      128'(busy), 128'(0));
    check("rst_aes_rstn",  128'(aes_rstn), 128'(0));
    check("rst_aes_en",    128'(aes_en), 128'(0));
    check("rst_err_done",  128'({err, done}), 128'(0));
    check("rst_kin",       aes_kin, 128'(0));
    check("rst_enc_count", 128'(enc_count), 128'(0));
    rst_n = 1'b1;
    step();

    // ---------------- FIPS-197 single encryption
    key_in = FIPS_KEY; pt_in = FIPS_PT; burst_len = 16'd1; idle_len = 16'd0; chain = 1'b0;
    clear_mon(); dc0 = done_cnt;
    pulse_start(1'b0);
    check("core_rst_en",   128'({busy, aes_en, aes_rstn}), 128'(3'b110));
    check("core_rst_kin",  aes_kin, FIPS_KEY);
    step();
    check("load_key",      128'({aes_krdy, aes_rstn}), 128'(2'b11));
    wait_done(100);
    check("fips_done",     128'(done), 128'(1));
    check("fips_ct",       last_ct, FIPS_CT);
    check("fips_count",    128'(enc_count), 128'(1));
    check("finish_core",   128'({aes_rstn, aes_en, busy}), 128'(3'b001));
    step();
    check("fips_idle",     128'({busy, done}), 128'(0));
    check("fips_done_cnt", 128'(done_cnt - dc0), 128'(1));

    // ---------------- chaining with idle gaps
    key_in = 128'h2b7e151628aed2a6abf7158809cf4f3c; pt_in = 128'h3243f6a8885a308d313198a2e0370734;
    burst_len = 16'd3; idle_len = 16'd5; chain = 1'b1;
    c1 = model_enc(key_in, pt_in);
    c2 = model_enc(key_in, c1);
    c3 = model_enc(key_in, c2);
    clear_mon(); dc0 = done_cnt;
    pulse_start(1'b0);
    wait_done(300);
    check("chain_done",    128'(done), 128'(1));
    check("chain_drdys",   128'(din_q.size()), 128'(3));
    if (din_q.size() == 3) begin
      check("chain_din0",  din_q[0], pt_in);
      check("chain_din1",  din_q[1], c1);
      check("chain_din2",  din_q[2], c2);
      check("chain_gap0",  128'(gap_q[0]), 128'(0));
      check("chain_gap1",  128'(gap_q[1]), 128'(5));
      check("chain_gap2",  128'(gap_q[2]), 128'(5));
    end
    check("chain_count",   128'(enc_count), 128'(3));
    check("chain_last_ct", last_ct, c3);
    check("chain_din_end", aes_din, c3);
    step();

    // ---------------- free-running counter mode, stop during encryption 10
    key_in = 128'hfeedface_0badf00d_deadbeef_cafebabe; pt_in = 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_fffc;
    burst_len = 16'd0; idle_len = 16'd0; chain = 1'b0;
    clear_mon(); dc0 = done_cnt;
    pulse_start(1'b0);
    wait_drdy(10, 200);
    check("free_reach10",  128'(din_q.size()), 128'(10));
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("free_not_yet",  128'(done), 128'(0));
    step();
    check("free_done",     128'(done), 128'(1));
    check("free_count",    128'(enc_count), 128'(10));
    check("free_din",      aes_din, pt_in + 128'd10);
    check("free_last_ct",  last_ct, model_enc(key_in, pt_in + 128'd9));
    step();
    check("free_drdys",    128'(din_q.size()), 128'(10));
    check("free_done_cnt", 128'(done_cnt - dc0), 128'(1));

    // ---------------- watchdog on a silent core
    burst_len = 16'd1; hang_dvld = 1'b1;
    clear_mon(); dc0 = done_cnt;
    pulse_start(1'b0);
    wait_drdy(1, 100);
    repeat (1022) step();
    check("wd_before",     128'({err, busy}), 128'(2'b01));
    step();
    check("wd_err",        128'({err, busy, aes_rstn, aes_en}), 128'(4'b1000));
    step(); step();
    check("wd_no_done",    128'(done_cnt - dc0), 128'(0));
    check("wd_sticky",     128'(err), 128'(1));
    hang_dvld = 1'b0;
    pulse_start(1'b0);
    check("wd_err_clear",  128'({err, busy}), 128'(2'b01));
    wait_done(100);
    check("wd_recover",    128'({done, enc_count}), {111'(0), 1'b1, 16'd1});
    step();

    // ---------------- start while busy is ignored
    key_in = 128'h11; pt_in = 128'h22; burst_len = 16'd2; idle_len = 16'd3; chain = 1'b0;
    clear_mon(); dc0 = done_cnt;
    pulse_start(1'b0);
    step(); step();
    key_in = 128'h99; pt_in = 128'h88; burst_len = 16'd7;
    pulse_start(1'b0);
    check("busy_kin",      aes_kin, 128'h11);
    wait_done(200);
    check("busy_count",    128'(enc_count), 128'(2));
    check("busy_din0",     din_q.size() > 0 ? din_q[0] : 128'hx, 128'h22);
    step();
    check("busy_done_cnt", 128'(done_cnt - dc0), 128'(1));

    // ---------------- stop alone in IDLE, then start+stop together
    stop = 1'b1; step(); stop = 1'b0;
    check("idle_stop",     128'(busy), 128'(0));
    key_in = 128'h33; pt_in = 128'h44; burst_len = 16'd2; idle_len = 16'd0;
    clear_mon();
    pulse_start(1'b1);
    wait_done(200);
    check("ss_count",      128'(enc_count), 128'(2));
    check("ss_drdys",      128'(din_q.size()), 128'(2));
    step();

    // ---------------- asynchronous reset mid-GAP
    burst_len = 16'd3; idle_len = 16'd8;
    clear_mon(); dc0 = done_cnt;
    pulse_start(1'b0);
    wait_drdy(1, 100);
    repeat (4) step();
    check("gap_pre",       128'({busy, aes_en}), 128'(2'b10));
    #2 rst_n = 1'b0;
    #1;
    check("arst_ctrl",     128'({busy, aes_en, aes_rstn, aes_krdy, aes_drdy, done, err}), 128'(0));
    check("arst_data",     aes_din | aes_kin | last_ct, 128'(0));
    check("arst_count",    128'(enc_count), 128'(0));
    step();
    rst_n = 1'b1;
    repeat (12) step();
    check("arst_no_done",  128'(done_cnt - dc0), 128'(0));
    check("arst_idle",     128'(busy), 128'(0));

    // ---------------- stop while waiting for key expansion
    klat = 6; burst_len = 16'd4; idle_len = 16'd0;
    clear_mon(); dc0 = done_cnt;
    pulse_start(1'b0);
    step(); step();
    stop = 1'b1; step(); stop = 1'b0;
    check("kstop_waiting", 128'({busy, done}), 128'(2'b10));
    wait_done(100);
    check("kstop_done",    128'(done), 128'(1));
    check("kstop_count",   128'(enc_count), 128'(0));
    check("kstop_drdys",   128'(din_q.size()), 128'(0));
    step();
    check("kstop_idle",    128'(busy), 128'(0));
    klat = 2;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
